// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for one shared combinational ALU.
// Operands are registered toward the ALU, and the result is registered back under valid/ready.
module alu_req_arbiter #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = DATA_W/2,
  parameter int SH_W   = 5,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [IMM_W-1:0]  req0_imm,
  input  logic [SH_W-1:0]   req0_sh,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [IMM_W-1:0]  req1_imm,
  input  logic [SH_W-1:0]   req1_sh,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [IMM_W-1:0]  alu_imm,
  output logic [SH_W-1:0]   alu_sh,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [IMM_W-1:0]  imm;
    logic [SH_W-1:0]   sh;
  } req_t;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  req_t              alu_q, alu_d;
  req_t              req0_s, req1_s;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic              hs, grant, accept;

  assign req0_s = '{op: req0_op, in1: req0_in1, in2: req0_in2, imm: req0_imm, sh: req0_sh};
  assign req1_s = '{op: req1_op, in1: req1_in1, in2: req1_in2, imm: req1_imm, sh: req1_sh};

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: grant is only offered in IDLE; on contention rr breaks the tie
  always_comb begin
    req0_ready = (state_q == IDLE) & req0_valid & (!req1_valid | !rr_q);
    req1_ready = (state_q == IDLE) & req1_valid & (!req0_valid |  rr_q);
    hs         = req0_ready | req1_ready;
    grant      = req1_ready;
    accept     = (state_q == RESP) & rsp_ready;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    rr_d         = rr_q;
    alu_d        = alu_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    done_cnt_d   = done_cnt_q;
    if (hs) begin
      alu_d    = grant ? req1_s : req0_s;
      rsp_id_d = grant;
    end
    if (state_q == EXEC) begin
      rsp_result_d = alu_result;
      rsp_valid_d  = 1'b1;
    end
    if (accept) begin
      rsp_valid_d = 1'b0;
      rr_d        = ~rsp_id_q;
      done_cnt_d  = (done_cnt_q == '1) ? done_cnt_q : done_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q         <= 1'b0;
      alu_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      done_cnt_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      alu_q        <= alu_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign alu_in1    = alu_q.in1;
  assign alu_in2    = alu_q.in2;
  assign alu_imm    = alu_q.imm;
  assign alu_sh     = alu_q.sh;
  assign alu_op     = alu_q.op;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign done_cnt   = done_cnt_q;

endmodule
